// File: rtl/shifter_pipe_if.sv
// Operation and result handshake bundle for shifter_pipe.
// The master drives operations and accepts results; the slave is the shifter.
interface shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_illegal
  );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage valid/ready barrel shifter: stage 1 applies the low half of the
// shift amount, stage 2 the high half; carry is taken from the original operand.
module shifter_pipe #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  shifter_pipe_if.slave bus
);
  localparam int SHW     = $clog2(WIDTH);
  localparam int LO_BITS = (SHW + 1) / 2;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       mode,
                                                  input int               k);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode)
      MODE_SLL: r = d << k;
      MODE_SRL: r = d >> k;
      MODE_SRA: r = $unsigned($signed(d) >>> k);
      MODE_ROR: r = (d >> k) | (d << (WIDTH - k));
      MODE_ROL: r = (d << k) | (d >> (WIDTH - k));
      default:  r = d;
    endcase
    return r;
  endfunction

  // Log-stage shifter over amount bits [lo, hi): each set bit i shifts by 2**i.
  function automatic logic [WIDTH-1:0] shift_bits(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       mode,
                                                  input logic [SHW-1:0]   amt,
                                                  input int               lo,
                                                  input int               hi);
    logic [WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < SHW; i++) begin
      if (i >= lo && i < hi && amt[i]) r = shift_step(r, mode, 1 << i);
    end
    return r;
  endfunction

  function automatic logic carry_of(input logic [WIDTH-1:0] d,
                                    input logic [2:0]       mode,
                                    input logic [SHW-1:0]   amt);
    logic [SHW-1:0] idx_left;
    logic [SHW-1:0] idx_right;
    logic           c;
    idx_left  = ~amt + SHW'(1);
    idx_right = amt - SHW'(1);
    c         = 1'b0;
    if (amt != '0) begin
      case (mode)
        MODE_SLL, MODE_ROL:           c = d[idx_left];
        MODE_SRL, MODE_SRA, MODE_ROR: c = d[idx_right];
        default:                      c = 1'b0;
      endcase
    end
    return c;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] data_p1_q, data_p1_d;
  logic [2:0]       mode_p1_q, mode_p1_d;
  logic [SHW-1:0]   amt_p1_q, amt_p1_d;
  logic             carry_p1_q, carry_p1_d;
  logic             ill_p1_q, ill_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] data_p2_q, data_p2_d;
  logic             carry_p2_q, carry_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             ill_p2_q, ill_p2_d;

  logic             s2_can_load;
  logic             in_ready;
  logic             load_p1;
  logic             load_p2;
  logic [WIDTH-1:0] shifted_p2;

  assign s2_can_load = !vld_p2_q || bus.out_ready;
  assign in_ready    = !vld_p1_q || s2_can_load;
  assign load_p1     = bus.in_valid && in_ready;
  assign load_p2     = s2_can_load && vld_p1_q;
  assign shifted_p2  = shift_bits(data_p1_q, mode_p1_q, amt_p1_q, LO_BITS, SHW);

  // ---- stage 1: low amount bits, carry from the original operand
  always_comb begin
    vld_p1_d   = in_ready ? bus.in_valid : vld_p1_q;
    data_p1_d  = data_p1_q;
    mode_p1_d  = mode_p1_q;
    amt_p1_d   = amt_p1_q;
    carry_p1_d = carry_p1_q;
    ill_p1_d   = ill_p1_q;
    if (load_p1) begin
      data_p1_d  = shift_bits(bus.in_data, bus.in_mode, bus.in_amt, 0, LO_BITS);
      mode_p1_d  = bus.in_mode;
      amt_p1_d   = bus.in_amt;
      carry_p1_d = carry_of(bus.in_data, bus.in_mode, bus.in_amt);
      ill_p1_d   = (bus.in_mode > MODE_ROL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
    data_p1_q  <= data_p1_d;
    mode_p1_q  <= mode_p1_d;
    amt_p1_q   <= amt_p1_d;
    carry_p1_q <= carry_p1_d;
    ill_p1_q   <= ill_p1_d;
  end

  // ---- stage 2: high amount bits, registered result and zero flag
  always_comb begin
    vld_p2_d   = s2_can_load ? vld_p1_q : vld_p2_q;
    data_p2_d  = data_p2_q;
    carry_p2_d = carry_p2_q;
    zero_p2_d  = zero_p2_q;
    ill_p2_d   = ill_p2_q;
    if (load_p2) begin
      data_p2_d  = shifted_p2;
      carry_p2_d = carry_p1_q;
      zero_p2_d  = (shifted_p2 == '0);
      ill_p2_d   = ill_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      carry_p2_q <= 1'b0;
      zero_p2_q  <= 1'b0;
      ill_p2_q   <= 1'b0;
    end else begin
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      carry_p2_q <= carry_p2_d;
      zero_p2_q  <= zero_p2_d;
      ill_p2_q   <= ill_p2_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_p2_q;
  assign bus.out_data    = data_p2_q;
  assign bus.out_carry   = carry_p2_q;
  assign bus.out_zero    = zero_p2_q;
  assign bus.out_illegal = ill_p2_q;
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed-vector, corner-sequence and random scoreboard bench for shifter_pipe.
module tb_shifter_pipe;
  localparam int WIDTH = 16;
  localparam int NOPS  = 10000;
  localparam int LIMIT = 80000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(WIDTH)) bus ();
  shifter_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] data;
    logic [3:0]  amt;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        ill;
  } res_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d,
                       input logic [3:0] a);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_amt   = a;
  endtask

  function automatic res_t ref_model(input logic [2:0] m, input logic [15:0] d,
                                     input logic [3:0] a);
    res_t r;
    int   n;
    n       = int'(a);
    r.data  = d;
    r.carry = 1'b0;
    r.ill   = 1'b0;
    case (m)
      3'b000: begin r.data = d << n; if (n > 0) r.carry = d[16-n]; end
      3'b001: begin r.data = d >> n; if (n > 0) r.carry = d[n-1]; end
      3'b010: begin r.data = 16'($signed(d) >>> n); if (n > 0) r.carry = d[n-1]; end
      3'b011: if (n > 0) begin r.data = (d >> n) | (d << (16 - n)); r.carry = d[n-1]; end
      3'b100: if (n > 0) begin r.data = (d << n) | (d >> (16 - n)); r.carry = d[16-n]; end
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.data == 16'h0000);
    return r;
  endfunction

  vec_t vecs[16];
  res_t q[$];
  res_t e;
  res_t held_v;
  logic held;
  int   sent, got, cyc, duty;

  initial begin
    vecs[0]  = '{3'b010, 16'h8001, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 16'h1234, 4'd4,  16'h4123, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b100, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 16'h00FF, 4'd0,  16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b110, 16'hA5A5, 4'd3,  16'hA5A5, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b001, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 16'h4000, 4'd14, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 16'h0000, 4'd5,  16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{3'b001, 16'hF0F0, 4'd5,  16'h0787, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b010, 16'h8421, 4'd3,  16'hF084, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b100, 16'h0F00, 4'd8,  16'h000F, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b000, 16'h0003, 4'd14, 16'hC000, 1'b0, 1'b0, 1'b0};

    // Reset held with a valid operation offered: nothing captured, outputs cleared.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b000, 16'h1234, 4'd1);
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 4'd0);
    step();
    chk("post_rst_idle0", 32'(bus.out_valid), 32'd0);
    step();
    chk("post_rst_idle1", 32'(bus.out_valid), 32'd0);

    // Directed vectors; inputs are scrambled right after acceptance.
    for (int i = 0; i < 16; i++) begin
      step();
      drive(1'b1, vecs[i].mode, vecs[i].data, vecs[i].amt);
      step();
      drive(1'b0, 3'b000, 16'hFFFF, 4'd7);
      #1;
      chk($sformatf("vec%0d_lat1_valid", i), 32'(bus.out_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_carry", i), 32'(bus.out_carry), 32'(vecs[i].exp_carry));
      chk($sformatf("vec%0d_zero", i), 32'(bus.out_zero), 32'(vecs[i].exp_zero));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].exp_ill));
    end
    step();
    step();

    // Backpressure: three back-to-back operations, downstream stalled three cycles.
    step();
    drive(1'b1, 3'b000, 16'h0001, 4'd1);
    step();
    drive(1'b1, 3'b001, 16'h8000, 4'd4);
    #1;
    chk("bp_c1_valid", 32'(bus.out_valid), 32'd0);
    step();
    drive(1'b1, 3'b011, 16'h00F1, 4'd4);
    bus.out_ready = 1'b0;
    #1;
    for (int c = 2; c <= 4; c++) begin
      if (c > 2) begin step(); #1; end
      chk($sformatf("bp_c%0d_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_c%0d_data", c), 32'(bus.out_data), 32'h0002);
      chk($sformatf("bp_c%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_c5_data", 32'(bus.out_data), 32'h0002);
    chk("bp_c5_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 3'b000, 16'h0000, 4'd0);
    #1;
    chk("bp_c6_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_c6_data", 32'(bus.out_data), 32'h0800);
    step();
    chk("bp_c7_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_c7_data", 32'(bus.out_data), 32'h100F);
    chk("bp_c7_carry", 32'(bus.out_carry), 32'd0);
    step();
    chk("bp_c8_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation: two accepted operations are discarded.
    step();
    drive(1'b1, 3'b000, 16'h00FF, 4'd4);
    step();
    drive(1'b1, 3'b100, 16'h0001, 4'd3);
    step();
    drive(1'b0, 3'b000, 16'h0000, 4'd0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b010, 16'h8000, 4'd4);
    #1;
    chk("mrst_valid_cleared", 32'(bus.out_valid), 32'd0);
    chk("mrst_data_cleared", 32'(bus.out_data), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 3'b000, 16'h0000, 4'd0);
    #1;
    chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
    step();
    chk("mrst_new_valid", 32'(bus.out_valid), 32'd1);
    chk("mrst_new_data", 32'(bus.out_data), 32'hF800);
    chk("mrst_new_carry", 32'(bus.out_carry), 32'd0);
    step();
    chk("mrst_drained", 32'(bus.out_valid), 32'd0);

    // Random traffic against the reference model with random backpressure.
    sent = 0;
    got  = 0;
    cyc  = 0;
    held = 1'b0;
    duty = 70;
    while (got < NOPS && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc % 1000 == 0) duty = int'($urandom_range(20, 100));
      if (sent < NOPS)
        drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
              4'($urandom_range(0, 15)));
      else
        drive(1'b0, 3'b000, 16'h0000, 4'd0);
      bus.out_ready = (int'($urandom_range(0, 99)) < duty);
      @(negedge clk);
      if (held)
        chk("rand_stall_hold",
            32'({bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_illegal}),
            32'({1'b1, held_v.data, held_v.carry, held_v.zero, held_v.ill}));
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_model(bus.in_mode, bus.in_data, bus.in_amt));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_result",
              32'({bus.out_data, bus.out_carry, bus.out_zero, bus.out_illegal}),
              32'({e.data, e.carry, e.zero, e.ill}));
        end
        got++;
      end
      held = bus.out_valid && !bus.out_ready;
      held_v.data  = bus.out_data;
      held_v.carry = bus.out_carry;
      held_v.zero  = bus.out_zero;
      held_v.ill   = bus.out_illegal;
    end
    chk("rand_all_received", 32'(got), 32'(NOPS));
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter: WIDTH, default 16, data width; SHALL be a power of two, at least 4.
REQ-002 Derived constant: SHW = log2(WIDTH), the shift-amount width; SHALL NOT be overridable.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  the upstream operation is valid this cycle.
REQ-006 Port: in_ready  output  1  the block accepts the operation this cycle.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_amt  input  SHW  unsigned shift amount, 0..WIDTH-1.
REQ-009 Port: in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101-111 illegal.
REQ-010 Port: out_valid  output  1  the result is valid.
REQ-011 Port: out_ready  input  1  downstream accepts the result.
REQ-012 Port: out_data  output  WIDTH  shifted result.
REQ-013 Port: out_carry  output  1  last bit shifted or rotated out; 0 when the amount is 0.
REQ-014 Port: out_zero  output  1  asserted when out_data equals 0.
REQ-015 Port: out_illegal  output  1  the mode was 101-111.

Function
REQ-016 The block SHALL be a two-stage pipeline: stage 1 applies the low ceil(SHW/2) amount bits, stage 2 applies the remaining bits; both stages SHALL use log-stage binary shifting (1, 2, 4, ... positions).
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty, or when its contents move on in the same cycle.
REQ-019 in_ready SHALL equal !s1_valid || s2_can_load, where s2_can_load = !out_valid || out_ready. in_ready SHALL be combinational on out_ready, and SHALL NOT depend on in_valid.
REQ-020 Latency: with no stall, the result SHALL appear on out_valid exactly 2 cycles after acceptance; throughput SHALL be 1 result per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_carry, out_zero and out_illegal SHALL hold stable.
REQ-022 Results SHALL leave in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-023 SLL SHALL zero-fill from the LSB; SRL SHALL zero-fill from the MSB; SRA SHALL fill with the original bit WIDTH-1.
REQ-024 ROR and ROL SHALL rotate modulo WIDTH with no loss of bits.
REQ-025 A shift amount of 0 SHALL pass the data unchanged in every legal mode.
REQ-026 Carry for amount n>0 SHALL be computed in stage 1 from the original operand and then piped:
- SLL and ROL: in_data[WIDTH-n]
- SRL, SRA and ROR: in_data[n-1]
REQ-027 out_zero SHALL be registered in stage 2 together with out_data.
REQ-028 For an illegal mode: out_data SHALL equal in_data, out_carry SHALL be 0, out_illegal SHALL be 1, and the handshake SHALL be unaffected.
REQ-029 Mode and amount SHALL be captured at acceptance; changes on the inputs afterwards SHALL NOT affect operations already in flight.

Reset
REQ-030 When rst=1 at a clock edge, s1_valid and out_valid SHALL become 0, and out_data, out_carry, out_zero and out_illegal SHALL become 0.
REQ-031 Reset SHALL take priority over any transfer in the same cycle; operations in flight SHALL be discarded and never emitted.
REQ-032 While rst=1, in_ready SHALL read 1 (both stages empty), and no input SHALL be captured at that edge.
REQ-033 After rst returns to 0, the first accepted operation SHALL emit 2 cycles later.

Verification
REQ-034 Tests SHALL use WIDTH=16 with out_ready held at 1.
REQ-035 The bench SHALL cover the following directed scenarios:
- SRA 0x8001 by 15 -> out_data 0xFFFF, out_carry 0, out_zero 0, 2 cycles after acceptance.
- ROR 0x1234 by 4 -> 0x4123, carry 0.
- ROL 0x8001 by 1 -> 0x0003, carry 1.
- SLL 0x8000 by 1 -> 0x0000, carry 1, zero 1.
- SRL 0x00FF by 0 -> 0x00FF, carry 0.
- Mode 110, data 0xA5A5, amount 3 -> out_data 0xA5A5, out_illegal 1, carry 0.
- Backpressure: send 3 back-to-back operations with out_ready=0 for 3 cycles from the first out_valid -> in_ready drops once both stages are full; all 3 results emerge in order, each held stable while stalled, with no duplicate.
- Reset mid-operation: accept 2 operations, assert rst for 1 cycle -> out_valid 0 next cycle, neither result ever appears; a new operation accepted after reset emits 2 cycles later with correct data.
- Random: 10k random data/amount/mode with a random out_ready duty cycle -> outputs match the reference model in order.
